// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write channels of the RV32I instruction encoder.
// The slave modport is the encoder side; master is the producer/memory side.
interface instr_encoder_if #(
  parameter int unsigned ADDR_WIDTH = 6
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_kind;
  logic [2:0]            in_func3;
  logic [6:0]            in_func7;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [31:0]           out_word;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  full;
  logic                  err;

  modport slave (
    input  in_valid, in_kind, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_word, word_count, full, err
  );

  modport master (
    output in_valid, in_kind, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_word, word_count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder (load/store/R-type/branch) writing sequential instruction-memory words.
// Optional immediate range checking is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input logic               clk,
  input logic               rst,
  input logic               clear,
  instr_encoder_if.slave    bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_word_q, out_word_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH+1:0] occupancy;
  logic                  in_ready, accept, write, imm_err;
  logic [31:0]           enc_word;

  // Written words plus the pending one must stay below DEPTH so addresses never wrap.
  assign occupancy = {1'b0, count_q} + {{(ADDR_WIDTH + 1){1'b0}}, out_valid_q};
  assign in_ready  = !rst && !clear && (occupancy < (ADDR_WIDTH + 2)'(Depth)) &&
                     (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign write     = out_valid_q && bus.out_ready;

  always_comb begin
    enc_word = '0;
    unique case (bus.in_kind)
      2'b00: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, 7'b0000011};
      2'b01: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_func3,
                         bus.in_imm[4:0], 7'b0100011};
      2'b10: enc_word = {bus.in_func7, bus.in_rs2, bus.in_rs1, bus.in_func3, bus.in_rd,
                         7'b0110011};
      2'b11: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                         bus.in_func3, bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
      default: enc_word = '0;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  logic               err_q;

  assign imm_s = bus.in_imm;

  always_comb begin
    imm_err = 1'b0;
    unique case (bus.in_kind)
      2'b00, 2'b01: imm_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      2'b11:        imm_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.in_imm[0];
      default:      imm_err = 1'b0;
    endcase
  end

  // Sticky until reset; clear deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && imm_err) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_imm;

  assign imm_err    = 1'b0;
  assign bus.err    = 1'b0;
  assign unused_imm = ^{bus.in_imm[31:13], bus.in_imm[0]};
`endif

  always_comb begin
    count_d     = count_q + {{ADDR_WIDTH{1'b0}}, write};
    out_valid_d = out_valid_q && !write;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    if (accept && !imm_err) begin
      out_valid_d = 1'b1;
      out_word_d  = enc_word;
      // Address follows the count after any write completing in this same cycle.
      out_addr_d  = count_d[ADDR_WIDTH-1:0];
    end
    if (clear) begin
      out_valid_d = 1'b0;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_word   = out_word_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.word_count = count_q;
  assign bus.full       = (count_q == (ADDR_WIDTH + 1)'(Depth));
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder, the inverse of the core's control/main decoder: it takes decoded fields (instruction kind, func3, func7, register indices, immediate) over a valid/ready handshake. It packs them into 32-bit machine words for the four instruction classes the core decodes: load, store, R-type and branch. Each word is written to sequential instruction-memory addresses. It is used by the test infrastructure and boot loader to build programs in instruction memory without an external assembler.

## Interface
- ADDR_WIDTH, 6, word-address width; DEPTH = 2**ADDR_WIDTH words
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- clear  input  1  synchronous flush: drop pending word, word counter to 0
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- in_kind  input  2  00 load (op 0000011), 01 store (0100011), 10 R-type (0110011), 11 branch (1100011)
- in_func3  input  3  func3 field
- in_func7  input  7  func7 field (R-type only, ignored otherwise)
- in_rd, in_rs1, in_rs2  input  5 each  register indices (unused fields ignored per kind)
- in_imm  input  32  signed immediate, byte offset
- out_valid  output  1  encoded word pending
- out_ready  input  1  instruction memory accepts write
- out_addr  output  ADDR_WIDTH  word address of pending word
- out_word  output  32  encoded instruction
- word_count  output  ADDR_WIDTH+1  words written since reset/clear
- full  output  1  word_count == DEPTH
- err  output  1  sticky immediate-range error (see Configuration)

## Operation
- Encoding, with op from in_kind:
  - load: imm[11:0] | rs1 | func3 | rd | op
  - store: imm[11:5] | rs2 | rs1 | func3 | imm[4:0] | op
  - R-type: func7 | rs2 | rs1 | func3 | rd | op
  - branch: imm[12] | imm[10:5] | rs2 | rs1 | func3 | imm[4:1] | imm[11] | op
- Immediate bits above the field width are discarded; branch imm[0] is discarded.
- Single output register (out_valid/out_word/out_addr), no further buffering.
- Acceptance: in_valid && in_ready.
- in_ready = !rst && !clear && (word_count + out_valid < DEPTH) && (!out_valid || out_ready). This gives full throughput under continuous out_ready.
- Write completes on out_valid && out_ready. word_count increments by 1; out_valid falls unless a new request is accepted in the same cycle.
- out_addr = word_count at the time the word is loaded into the output register; addresses are strictly sequential from 0.
- No wrap-around: at word_count == DEPTH, full=1 and in_ready=0 until clear or rst.
- clear beats a concurrent accept and a concurrent write. Pending word is dropped without counting; out_valid=0, word_count=0. err is not cleared.
- rst: out_valid=0, out_word=0, out_addr=0, word_count=0, full=0, err=0, in_ready=0 during reset.

## Timing
- Latency: request accepted at edge N → out_valid=1 with its word/address after edge N, visible in cycle N+1.
- Back-to-back: one word per cycle while out_ready=1.
- out_valid, out_word and out_addr hold stable while out_valid && !out_ready.
- full asserts the cycle after the DEPTH-th write completes.

## Configuration
- INSTR_ENCODER_RANGE_CHECK_EN defined:
  - Load/store immediates outside [-2048, 2047] are range errors.
  - Branch immediates outside [-4096, 4094], or odd, are range errors.
  - An erroring request is accepted (handshake completes), but no word is produced and word_count is unchanged; err is set sticky until rst.
- INSTR_ENCODER_RANGE_CHECK_EN undefined: immediates are truncated silently, and err is tied to 0.

## Test plan
- After rst, send R-type func3=000 func7=0 rd=3 rs1=1 rs2=2 with out_ready=1 → cycle+1: out_word=0x002081B3, out_addr=0; word_count=1 after the write.
- Back-to-back stream with out_ready=1:
  - load func3=010 rd=5 rs1=0 imm=8 → 0x00802283 at addr 0
  - store func3=010 rs1=0 rs2=6 imm=12 → 0x00602623 at addr 1
  - branch func3=000 rs1=1 rs2=2 imm=-8 → 0xFE208CE3 at addr 2
  - in_ready stays 1 throughout.
- Hold out_ready=0 for 5 cycles with a word pending → in_ready=0, out_word/out_addr unchanged, word_count unchanged; the word is written on the first out_ready=1 cycle.
- Write DEPTH words (64) → full=1, in_ready=0, a 65th request is not accepted; pulse clear → word_count=0, full=0, next word lands at addr 0.
- Assert clear in the same cycle as an accept and a pending write → out_valid=0 next cycle, word_count=0, no word produced for either.
- With INSTR_ENCODER_RANGE_CHECK_EN, send load imm=4096 → accepted, no out_valid, err=1, word_count unchanged; without the macro → out_word=0x00002283-style truncation (imm field 0), err=0.
